rv_multicycle_ctrl: RTL
=======================

# rv_multicycle_ctrl

Multi-cycle control FSM for the RV64I core. It sequences the shared datapath (PC, instruction register, ALU, register file, unified memory port and immediate generator) through fetch, decode, execute, memory and write-back. It derives every datapath select and strobe from the latched instruction's opcode. It sits between the IR and the datapath muxes, and it owns the `imm_sel` input of the immediate generator.

## Interface
Parameters:
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr`  in  32  contents of the instruction register.
- `mem_ready`  in  1  memory port completion, valid while `mem_req`=1.
- `br_taken`  in  1  branch comparator result for the funct3 in `instr`.
- `mem_req`  out  1  memory access request; held until `mem_ready`.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `mem_addr_sel`  out  1  memory address source: 0=PC, 1=ALUOut.
- `ir_write`  out  1  latch memory read data into the IR.
- `pc_write`  out  1  PC load strobe.
- `pc_src`  out  2  PC source: 0=ALU result, 1=ALUOut, 2=ALU result with bit0 cleared (JALR).
- `imm_sel`  out  3  selects the immediate format of the immediate generator.
- `alu_src_a`  out  2  ALU A operand: 0=PC, 1=rs1, 2=oldPC, 3=zero.
- `alu_src_b`  out  2  ALU B operand: 0=rs2, 1=imm, 2=const 4.
- `alu_op`  out  2  ALU operation: 0=add, 1=sub/compare, 2=funct-decoded.
- `reg_write`  out  1  register-file write enable.
- `wb_sel`  out  2  write-back source: 0=ALUOut, 1=MDR, 2=PC.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `instret`  out  CNT_W  count of retired instructions.
- `illegal`  out  1  unrecognised opcode flag (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are Moore-decoded from the state and the latched `instr` opcode, except `ir_write` and `pc_write` in FETCH, which are qualified by `mem_ready`.
- FETCH:
  - `mem_req`=1, `mem_addr_sel`=0, `alu_src_a`=0, `alu_src_b`=2.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1 with `pc_src`=0 (PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUOut ← oldPC+imm (`alu_src_a`=2, `alu_src_b`=1), used as the branch/JAL target. Always go to EXEC.
- EXEC, by opcode class:
  - OP / OP-32: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2 → WB.
  - OP-IMM / OP-IMM-32: `alu_src_b`=1, `imm_sel`=I → WB.
  - LOAD / STORE: address rs1+imm (`imm_sel` I or S) → MEM.
  - BRANCH: `alu_op`=1, `imm_sel`=SB; `pc_write`=`br_taken`, `pc_src`=1; retire → FETCH.
  - LUI: `alu_src_a`=3, `imm_sel`=U. AUIPC: `alu_src_a`=2, `imm_sel`=U. Both → WB.
  - JAL: `imm_sel`=UJ, `pc_write`=1, `pc_src`=1, rd ← PC (`wb_sel`=2, `reg_write`=1); retire → FETCH.
  - JALR: same as JAL but `imm_sel`=I and `pc_src`=2.
  - Unknown opcode → TRAP if the macro is defined, else retire as NOP → FETCH.
- MEM:
  - `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE.
  - On `mem_ready`: LOAD → WB; STORE retires → FETCH.
  - Otherwise stay in MEM.
- WB: `reg_write`=1, `wb_sel`=1 for LOAD, else 0; retire → FETCH.
- `instret` increments by 1 on every `retire`. It wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH, `instret`=0. While `reset`=1, every output is forced to 0.
- The first `mem_req` appears in the cycle after `reset` deasserts.
- Reset during MEM or FETCH wait: `mem_req` drops in the reset cycle; the in-flight access is abandoned and nothing retires.
- Latency with zero-wait memory:
  - ALU / LUI / AUIPC: 4 cycles.
  - BRANCH / JAL / JALR / STORE / NOP: 3 cycles (STORE: 4).
  - LOAD: 5 cycles.
  - Each wait cycle on `mem_ready` adds 1.
- `retire` is asserted in the last cycle of each instruction. `instret` shows the new value one cycle later.
- `mem_ready` outside FETCH or MEM is ignored.

## Configuration
- `RV_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in EXEC → TRAP.
  - TRAP asserts `illegal`=1 and no other strobes, and stays there until `reset`. Nothing retires.
- Not defined: the TRAP state is not built, `illegal` is tied to 0, and unknown opcodes retire as NOP.

## Structure
- Shared package `rv_ctrl_pkg`:
  - state enum;
  - opcode constants (0110011, 0010011, 0111011, 0011011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111);
  - `imm_sel` encoding I=0, S=1, SB=2, U=3, UJ=4. The immediate generator uses the same encoding.
  - mux-select localparams.
- Sub-module `rv_opclass_decode`: combinational mapping of opcode to class and `imm_sel`.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `mem_req`=1 on the first post-reset cycle; `instret`=0.
- `addi` 0x00108113 with `mem_ready` always 1 → FETCH→DECODE→EXEC(`imm_sel`=0)→WB(`reg_write`=1); `retire` at cycle 4; `instret`=1.
- `lw` with `mem_ready` low for 2 cycles in MEM → `mem_req`/`mem_addr_sel`=1 are held 3 cycles; WB `wb_sel`=1; 7 cycles total.
- `beq` 0xFE208EE3 with `br_taken`=1, then again with `br_taken`=0 → EXEC `imm_sel`=2; `pc_write`=1 with `pc_src`=1 only in the taken case.
- `jal` then `lui` → `imm_sel`=4 with `pc_write`, `reg_write` and `wb_sel`=2; then `imm_sel`=3 with `alu_src_a`=3.
- Instruction 0xFFFFFFFF → `illegal`=1 sticky with the macro defined; retired as NOP (`instret`+1) without it. Reset asserted mid-MEM → back to FETCH and `instret` unchanged.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state, opcode, immediate-format and mux-select definitions for the multicycle control path
// Optional feature macro: RV_CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package rv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;
  typedef enum logic [3:0] {
    C_OP,
    C_OPIMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_BAD
  } opclass_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_RS1   = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
endpackage

// File: rtl/rv_opclass_decode.sv
// rv_opclass_decode: maps a RV64I major opcode to its control class and immediate format
// Ports: opcode (in, 7) major opcode; cls (out) instruction class; imm_sel (out, 3) immediate format.
module rv_opclass_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls,
  output logic [2:0] imm_sel
);
  always_comb begin
    cls = C_BAD;
    imm_sel = IMM_I;
    case (opcode)
      OPC_OP, OPC_OP32:       cls = C_OP;
      OPC_OPIMM, OPC_OPIMM32: cls = C_OPIMM;
      OPC_LOAD:               cls = C_LOAD;
      OPC_JALR:               cls = C_JALR;
      OPC_STORE: begin
        cls = C_STORE;
        imm_sel = IMM_S;
      end
      OPC_BRANCH: begin
        cls = C_BRANCH;
        imm_sel = IMM_SB;
      end
      OPC_LUI: begin
        cls = C_LUI;
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        cls = C_AUIPC;
        imm_sel = IMM_U;
      end
      OPC_JAL: begin
        cls = C_JAL;
        imm_sel = IMM_UJ;
      end
      default: cls = C_BAD;
    endcase
  end
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multicycle RV64I control FSM driving the shared datapath selects and strobes
// Ports: clk, reset (sync, active-high); instr (IR contents); mem_ready, br_taken (status in);
//   mem_req/mem_we/mem_addr_sel (memory port); ir_write/pc_write/pc_src (IR and PC);
//   imm_sel/alu_src_a/alu_src_b/alu_op (immediate and ALU); reg_write/wb_sel (write-back);
//   retire/instret (completion pulse and counter); illegal (trap flag).
// Optional feature macro: RV_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes instead of retiring them as NOPs.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);
  state_t state, state_n;
  opclass_t cls;
  logic [2:0] dec_imm;
  logic unused_instr;
  assign unused_instr = ^instr[31:7];
  rv_opclass_decode u_dec (
    .opcode (instr[6:0]),
    .cls    (cls),
    .imm_sel(dec_imm)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_n;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end
  // Everything stays at its default while reset is high, so an abandoned access drops mem_req at once.
  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_ALU;
    imm_sel = IMM_I;
    alu_src_a = A_PC;
    alu_src_b = B_RS2;
    alu_op = ALU_ADD;
    reg_write = 1'b0;
    wb_sel = WB_ALUOUT;
    retire = 1'b0;
    illegal = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alu_src_b = B_FOUR;
          ir_write = mem_ready;
          pc_write = mem_ready;
          if (mem_ready) state_n = S_DECODE;
        end
        S_DECODE: begin
          imm_sel = dec_imm;
          alu_src_a = A_OLDPC;
          alu_src_b = B_IMM;
          state_n = S_EXEC;
        end
        S_EXEC: begin
          imm_sel = dec_imm;
          case (cls)
            C_OP: begin
              alu_src_a = A_RS1;
              alu_op = ALU_FUNCT;
              state_n = S_WB;
            end
            C_OPIMM: begin
              alu_src_a = A_RS1;
              alu_src_b = B_IMM;
              alu_op = ALU_FUNCT;
              state_n = S_WB;
            end
            C_LOAD, C_STORE: begin
              alu_src_a = A_RS1;
              alu_src_b = B_IMM;
              state_n = S_MEM;
            end
            C_BRANCH: begin
              alu_src_a = A_RS1;
              alu_op = ALU_SUB;
              pc_write = br_taken;
              pc_src = PC_ALUOUT;
              retire = 1'b1;
              state_n = S_FETCH;
            end
            C_LUI, C_AUIPC: begin
              alu_src_a = (cls == C_LUI) ? A_ZERO : A_OLDPC;
              alu_src_b = B_IMM;
              state_n = S_WB;
            end
            C_JAL: begin
              pc_write = 1'b1;
              pc_src = PC_ALUOUT;
              reg_write = 1'b1;
              wb_sel = WB_PC;
              retire = 1'b1;
              state_n = S_FETCH;
            end
            C_JALR: begin
              alu_src_a = A_RS1;
              alu_src_b = B_IMM;
              pc_write = 1'b1;
              pc_src = PC_JALR;
              reg_write = 1'b1;
              wb_sel = WB_PC;
              retire = 1'b1;
              state_n = S_FETCH;
            end
            default: begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
              state_n = S_TRAP;
`else
              retire = 1'b1;
              state_n = S_FETCH;
`endif
            end
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we = cls == C_STORE;
          retire = mem_ready && cls == C_STORE;
          if (mem_ready) state_n = (cls == C_STORE) ? S_FETCH : S_WB;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel = (cls == C_LOAD) ? WB_MDR : WB_ALUOUT;
          retire = 1'b1;
          state_n = S_FETCH;
        end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        S_TRAP: illegal = 1'b1;
`endif
        default: state_n = S_FETCH;
      endcase
    end
  end
endmodule
